// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
//   Bundles the run request and the raster outputs of video_timing_gen.
//   master : the timing generator (samples i_en, drives the raster signals)
//   slave  : a raster consumer (drives i_en, samples the raster signals)
//
//   i_en        run request, sampled every cycle
//   o_vs/o_hs   vertical / horizontal sync, active high
//   o_de        active pixel strobe
//   o_x/o_y     active column / row, valid when o_de
//   o_sof       pulse with the first o_de of a frame
//   o_eol       pulse with the last o_de of each line
//   o_busy      high while a frame is in progress
//   o_frame_cnt completed-frame count (wraps at 256)
// ---------------------------------------------------------------------------
interface video_timing_gen_if #(
    parameter int CNT_H_SIZE = 12,
    parameter int CNT_V_SIZE = 12
);
    logic                  i_en;
    logic                  o_vs;
    logic                  o_hs;
    logic                  o_de;
    logic [CNT_H_SIZE-1:0] o_x;
    logic [CNT_V_SIZE-1:0] o_y;
    logic                  o_sof;
    logic                  o_eol;
    logic                  o_busy;
    logic [7:0]            o_frame_cnt;

    modport master (
        input  i_en,
        output o_vs, o_hs, o_de, o_x, o_y, o_sof, o_eol, o_busy, o_frame_cnt
    );

    modport slave (
        output i_en,
        input  o_vs, o_hs, o_de, o_x, o_y, o_sof, o_eol, o_busy, o_frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator. Counts pixels (h) and lines (v) against the
//   parameterised sync / back porch / active / front porch sizes and decodes
//   vs, hs, de, active coordinates and sof/eol strobes. All outputs are
//   registered, so the pins lag the counters by one clock.
//   Starting and stopping only take effect on frame boundaries: dropping
//   i_en lets the current frame finish before the block goes idle.
//
//   clk   clock
//   rstn  asynchronous active-low reset
//   vif   video_timing_gen_if.master (i_en in, raster outputs out)
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int HAC        = 1920,
    parameter int HSW        = 1,
    parameter int HBP        = 3,
    parameter int HFP        = 3,
    parameter int VAC        = 1080,
    parameter int VSW        = 1,
    parameter int VBP        = 3,
    parameter int VFP        = 3,
    parameter int CNT_H_SIZE = 12,
    parameter int CNT_V_SIZE = 12
) (
    input  logic               clk,
    input  logic               rstn,
    video_timing_gen_if.master vif
);

    localparam int HTOT = HSW + HBP + HAC + HFP;
    localparam int VTOT = VSW + VBP + VAC + VFP;

    localparam logic [CNT_H_SIZE-1:0] H_ONE     = CNT_H_SIZE'(1);
    localparam logic [CNT_H_SIZE-1:0] H_LAST    = CNT_H_SIZE'(HTOT - 1);
    localparam logic [CNT_H_SIZE-1:0] H_SYNC    = CNT_H_SIZE'(HSW);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_BEG = CNT_H_SIZE'(HSW + HBP);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_END = CNT_H_SIZE'(HSW + HBP + HAC - 1);
    localparam logic [CNT_H_SIZE-1:0] X_LAST    = CNT_H_SIZE'(HAC - 1);

    localparam logic [CNT_V_SIZE-1:0] V_ONE     = CNT_V_SIZE'(1);
    localparam logic [CNT_V_SIZE-1:0] V_LAST    = CNT_V_SIZE'(VTOT - 1);
    localparam logic [CNT_V_SIZE-1:0] V_SYNC    = CNT_V_SIZE'(VSW);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_BEG = CNT_V_SIZE'(VSW + VBP);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_END = CNT_V_SIZE'(VSW + VBP + VAC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t                state;
    logic [CNT_H_SIZE-1:0] h_cnt;
    logic [CNT_V_SIZE-1:0] v_cnt;

    logic                  active;
    logic                  h_end;
    logic                  frame_end;
    logic                  hs_c;
    logic                  vs_c;
    logic                  de_c;
    logic [CNT_H_SIZE-1:0] x_c;
    logic [CNT_V_SIZE-1:0] y_c;
    logic                  sof_c;
    logic                  eol_c;

    // Combinational decode of the current counter position.
    always_comb begin
        active    = (state != IDLE);
        h_end     = (h_cnt == H_LAST);
        frame_end = h_end && (v_cnt == V_LAST);
        hs_c      = (h_cnt < H_SYNC);
        vs_c      = (v_cnt < V_SYNC);
        de_c      = (h_cnt >= H_ACT_BEG) && (h_cnt <= H_ACT_END) &&
                    (v_cnt >= V_ACT_BEG) && (v_cnt <= V_ACT_END);
        x_c       = h_cnt - H_ACT_BEG;
        y_c       = v_cnt - V_ACT_BEG;
        sof_c     = de_c && (x_c == '0) && (y_c == '0);
        eol_c     = de_c && (x_c == X_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            h_cnt           <= '0;
            v_cnt           <= '0;
            vif.o_vs        <= 1'b0;
            vif.o_hs        <= 1'b0;
            vif.o_de        <= 1'b0;
            vif.o_x         <= '0;
            vif.o_y         <= '0;
            vif.o_sof       <= 1'b0;
            vif.o_eol       <= 1'b0;
            vif.o_busy      <= 1'b0;
            vif.o_frame_cnt <= '0;
        end else begin
            // Registered decode; forced low while idle.
            vif.o_busy <= active;
            vif.o_hs   <= active && hs_c;
            vif.o_vs   <= active && vs_c;
            vif.o_de   <= active && de_c;
            vif.o_sof  <= active && sof_c;
            vif.o_eol  <= active && eol_c;
            // Coordinates only move on active pixels and hold otherwise.
            if (active && de_c) begin
                vif.o_x <= x_c;
                vif.o_y <= y_c;
            end

            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (vif.i_en) begin
                        state <= RUN;
                    end
                end
                default: begin
                    // RUN and STOP both keep the raster going; i_en only
                    // selects whether the frame boundary continues or idles.
                    if (h_end) begin
                        h_cnt <= '0;
                        v_cnt <= frame_end ? '0 : v_cnt + V_ONE;
                    end else begin
                        h_cnt <= h_cnt + H_ONE;
                    end

                    if (frame_end) begin
                        vif.o_frame_cnt <= vif.o_frame_cnt + 8'd1;
                        state           <= vif.i_en ? RUN : IDLE;
                    end else begin
                        state           <= vif.i_en ? RUN : STOP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Directed bench for video_timing_gen with small raster parameters
//   (HTOT=13, VTOT=7, 91 clocks per frame). Observation windows are 91
//   negedge samples long and start right after the negedge on which i_en
//   was raised, so every frame lands at the same window offsets: hs/vs at
//   index 2, first de (sof) at index 2 + 2*13 + 3 = 31.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int FRAME = 91;

    logic clk;
    logic rstn;

    video_timing_gen_if #(.CNT_H_SIZE(12), .CNT_V_SIZE(12)) vif ();

    video_timing_gen #(
        .HAC(8), .HSW(1), .HBP(2), .HFP(2),
        .VAC(4), .VSW(1), .VBP(1), .VFP(1),
        .CNT_H_SIZE(12), .CNT_V_SIZE(12)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .vif  (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window statistics
    int hs_cnt, vs_len, de_cnt, eol_cnt, eol_bad, sof_cnt, sof_bad, busy_cnt;
    int first_hs, first_vs, first_de;
    logic [7:0] fc_first;
    logic       busy_last;

    task automatic run_win(input int n, input int drop_at, input int raise_at);
        hs_cnt = 0; vs_len = 0; de_cnt = 0; eol_cnt = 0; eol_bad = 0;
        sof_cnt = 0; sof_bad = 0; busy_cnt = 0;
        first_hs = 0; first_vs = 0; first_de = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) fc_first = vif.o_frame_cnt;
            if (vif.o_hs) begin
                hs_cnt++;
                if (first_hs == 0) first_hs = c;
            end
            if (vif.o_vs) begin
                vs_len++;
                if (first_vs == 0) first_vs = c;
            end
            if (vif.o_de) begin
                de_cnt++;
                if (first_de == 0) first_de = c;
            end
            if (vif.o_eol) begin
                eol_cnt++;
                if (!vif.o_de || vif.o_x != 12'd7) eol_bad++;
            end
            if (vif.o_sof) begin
                sof_cnt++;
                if (!vif.o_de || vif.o_x != 12'd0 || vif.o_y != 12'd0 || c != first_de) sof_bad++;
            end
            if (vif.o_busy) busy_cnt++;
            busy_last = vif.o_busy;
            if (c == drop_at)  vif.i_en = 1'b0;
            if (c == raise_at) vif.i_en = 1'b1;
        end
    endtask

    task automatic check_full_frame(input string tag);
        check({tag, " first_hs"}, 64'(first_hs), 64'd2);
        check({tag, " first_vs"}, 64'(first_vs), 64'd2);
        check({tag, " vs_len"},   64'(vs_len),   64'd13);
        check({tag, " hs_cnt"},   64'(hs_cnt),   64'd7);
        check({tag, " first_de"}, 64'(first_de), 64'd31);
        check({tag, " de_cnt"},   64'(de_cnt),   64'd32);
        check({tag, " eol_cnt"},  64'(eol_cnt),  64'd4);
        check({tag, " eol_bad"},  64'(eol_bad),  64'd0);
        check({tag, " sof_cnt"},  64'(sof_cnt),  64'd1);
        check({tag, " sof_bad"},  64'(sof_bad),  64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({vif.o_vs, vif.o_hs, vif.o_de, vif.o_sof, vif.o_eol,
                    vif.o_busy, vif.o_frame_cnt, vif.o_x, vif.o_y});
    endfunction

    int       exp_fc;
    int       waited;

    initial begin
        rstn     = 1'b0;
        vif.i_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", all_outs(), 64'd0);
        rstn = 1'b1;

        // 1. idle with i_en low
        run_win(50, 0, 0);
        check("idle activity", 64'(hs_cnt + vs_len + de_cnt + eol_cnt + sof_cnt + busy_cnt), 64'd0);
        check("idle frame_cnt", 64'(vif.o_frame_cnt), 64'd0);

        // 2/3. start and free-run two frames
        vif.i_en = 1'b1;
        run_win(FRAME, 0, 0);
        check_full_frame("frame1");
        check("frame1 fc_first", 64'(fc_first), 64'd0);
        check("frame1 busy", 64'(busy_cnt), 64'd90);

        // 4. drop i_en during line 3 of frame 2: frame still completes
        run_win(FRAME, 45, 0);
        check_full_frame("frame2");
        check("frame2 fc_first", 64'(fc_first), 64'd1);

        // after the stopped frame: idle, raise i_en at the last sample
        run_win(FRAME, 0, FRAME);
        check("stopped fc_first", 64'(fc_first), 64'd2);
        check("stopped hs_cnt", 64'(hs_cnt), 64'd0);
        check("stopped de_cnt", 64'(de_cnt), 64'd0);
        check("stopped busy_cnt", 64'(busy_cnt), 64'd1);
        check("stopped frame_cnt", 64'(vif.o_frame_cnt), 64'd2);

        // pulse i_en low then high inside one frame: no gap
        run_win(FRAME, 40, 50);
        check_full_frame("pulseA");
        check("pulseA fc_first", 64'(fc_first), 64'd2);
        run_win(FRAME, 0, 0);
        check_full_frame("pulseB");
        check("pulseB fc_first", 64'(fc_first), 64'd3);

        // 5. 256 more frames: frame count wraps 255 -> 0
        exp_fc = 4;
        for (int f = 0; f < 256; f++) begin
            run_win(FRAME, 0, 0);
            if (exp_fc == 255 || exp_fc == 0)
                check($sformatf("wrap fc_first %0d", exp_fc), 64'(fc_first), 64'(exp_fc));
            check(f == 0 ? "wrap hs first" : "wrap hs", 64'(hs_cnt), 64'd7);
            exp_fc = (exp_fc + 1) % 256;
        end

        // 6. reset during an active pixel
        waited = 0;
        while (!vif.o_de && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("de seen before reset", 64'(vif.o_de), 64'd1);
        rstn = 1'b0;
        #1;
        check("async reset outputs", all_outs(), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_win(FRAME, 0, 0);
        check_full_frame("restart");
        check("restart fc_first", 64'(fc_first), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
